// File: rtl/incr_sequence_gen_if.sv
// Valid/ready stream carrying sequence values from the sequencer to its consumer.
interface incr_sequence_gen_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/incr_sequence_gen.sv
// Emits an inclusive start..end value sequence on a valid/ready stream, using an
// external combinational incrementer as the count feedback path.
module incr_sequence_gen #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     start_val,
    input  logic [WIDTH-1:0]     end_val,
    input  logic                 abort,
    output logic [WIDTH-1:0]     inc_a,
    input  logic [WIDTH-1:0]     inc_result,
    incr_sequence_gen_if.master  stream,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH:0]       beat_cnt
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] last;
    logic             xfer;

    assign xfer = (state == RUN) && stream.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            last     <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count    <= start_val;
                        last     <= end_val;
                        beat_cnt <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    // A beat accepted alongside abort still counts.
                    if (xfer)
                        beat_cnt <= beat_cnt + (WIDTH+1)'(1);
                    if (abort)
                        state <= IDLE;
                    else if (xfer) begin
                        if (count == last)
                            state <= DONE;
                        else
                            count <= inc_result;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign inc_a            = count;
    assign stream.out_data  = count;
    assign stream.out_valid = (state == RUN);
    assign busy             = (state == RUN);
    assign done             = (state == DONE);
endmodule

// File: tb/tb_incr_sequence_gen.sv
// Self-checking bench for incr_sequence_gen: vector table, hand sequences and random runs.
module tb_incr_sequence_gen;
    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] start_val;
    logic [3:0] end_val;
    logic       abort;
    logic [3:0] inc_a;
    logic [3:0] inc_result;
    logic       busy;
    logic       done;
    logic [4:0] beat_cnt;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    incr_sequence_gen_if #(.WIDTH(4)) stream ();

    incr_sequence_gen #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_val  (start_val),
        .end_val    (end_val),
        .abort      (abort),
        .inc_a      (inc_a),
        .inc_result (inc_result),
        .stream     (stream),
        .busy       (busy),
        .done       (done),
        .beat_cnt   (beat_cnt)
    );

    // The 4-bit incrementer the sequencer feeds.
    assign inc_result = inc_a + 4'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] s;
        logic [3:0] e;
        int         mode;      // 0: ready high, 1: ready 1,0,0 pattern, 2: random
        int         ab;        // beats before abort, -1 for none
        int         exp_beats;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input logic [3:0] s, input logic [3:0] e, input int mode,
                           input int ab, output int beats, output logic aborted);
        int         n;
        int         guard;
        logic [3:0] expv;
        logic       r;
        logic       abort_now;
        n       = ((int'(e) - int'(s)) & 15) + 1;
        beats   = 0;
        aborted = 1'b0;
        guard   = 0;
        start_val = s;
        end_val   = e;
        start     = 1'b1;
        cycle();
        check("start_latency", 32'(stream.out_valid), 32'd1);
        check("beat_cnt_clear", 32'(beat_cnt), 32'd0);
        while (stream.out_valid && guard < 400) begin
            expv = s + beats[3:0];
            check("seq_data", 32'(stream.out_data), 32'(expv));
            // Start and new bounds during RUN must have no effect.
            start     = 1'($urandom);
            start_val = 4'($urandom);
            end_val   = 4'($urandom);
            abort_now = (ab >= 0) && (beats == ab);
            case (mode)
                0:       r = 1'b1;
                1:       r = ((guard % 3) == 0);
                default: r = 1'($urandom);
            endcase
            if (abort_now && mode != 2) r = 1'b0;
            abort            = abort_now;
            stream.out_ready = r;
            if (r) beats++;
            if (abort_now) aborted = 1'b1;
            guard++;
            cycle();
            abort = 1'b0;
        end
        start            = 1'b0;
        stream.out_ready = 1'b0;
        if (guard >= 400) begin
            chk_cnt++;
            $display("FAIL seq_timeout: still valid after %0d cycles, expected end", guard);
        end
        check("done_pulse", 32'(done), aborted ? 32'd0 : 32'd1);
        check("beat_cnt", 32'(beat_cnt), 32'(beats));
        if (!aborted) check("beat_total", 32'(beats), 32'(n));
        if (!aborted) begin
            start     = 1'b1;  // offered during DONE, must be ignored
            start_val = s;
            end_val   = e;
        end
        cycle();
        start = 1'b0;
        check("idle_valid", 32'(stream.out_valid), 32'd0);
        check("done_once", 32'(done), 32'd0);
        cycle();
        check("idle_hold", 32'(stream.out_valid | busy), 32'd0);
        check("beat_cnt_hold", 32'(beat_cnt), 32'(beats));
    endtask

    initial begin
        int         beats;
        logic       aborted;
        logic [3:0] s;
        logic [3:0] e;
        int         ab;
        int         n;

        tbl[0] = '{4'd2,  4'd5, 0, -1, 4};
        tbl[1] = '{4'd14, 4'd1, 0, -1, 4};
        tbl[2] = '{4'd5,  4'd4, 0, -1, 16};
        tbl[3] = '{4'd0,  4'd3, 1, -1, 4};
        tbl[4] = '{4'd0,  4'd9, 0,  3, 3};
        tbl[5] = '{4'd7,  4'd7, 0, -1, 1};
        tbl[6] = '{4'd9,  4'd9, 2, -1, 1};
        tbl[7] = '{4'd15, 4'd0, 1, -1, 2};

        rst = 1'b0; start = 1'b0; start_val = '0; end_val = '0; abort = 1'b0;
        stream.out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("reset_valid", 32'(stream.out_valid), 32'd0);
        check("reset_outputs", 32'({busy, done, beat_cnt, stream.out_data, inc_a}), 32'd0);
        cycle();
        rst = 1'b0;
        cycle();
        check("idle_after_reset", 32'(stream.out_valid | busy | done), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_seq(tbl[i].s, tbl[i].e, tbl[i].mode, tbl[i].ab, beats, aborted);
            check("tbl_beats", 32'(beats), 32'(tbl[i].exp_beats));
        end

        // Single beat, start in DONE ignored, start in following IDLE accepted.
        start_val = 4'd7; end_val = 4'd7; start = 1'b1;
        cycle();
        start = 1'b0;
        check("b2b_first", 32'({stream.out_valid, stream.out_data}), 32'({1'b1, 4'd7}));
        stream.out_ready = 1'b1;
        cycle();
        check("b2b_done", 32'({done, stream.out_valid, beat_cnt}), 32'({1'b1, 1'b0, 5'd1}));
        start = 1'b1; start_val = 4'd3; end_val = 4'd3;
        cycle();
        check("b2b_ignored", 32'({stream.out_valid, done}), 32'd0);
        cycle();
        start = 1'b0;
        check("b2b_accepted", 32'({stream.out_valid, stream.out_data}), 32'({1'b1, 4'd3}));
        cycle();
        check("b2b_second_done", 32'({done, beat_cnt}), 32'({1'b1, 5'd1}));
        stream.out_ready = 1'b0;
        cycle();
        cycle();

        // Asynchronous reset in the middle of a sequence.
        start_val = 4'd3; end_val = 4'd9; start = 1'b1;
        cycle();
        start = 1'b0;
        stream.out_ready = 1'b1;
        cycle();
        cycle();
        check("pre_reset_data", 32'(stream.out_data), 32'd5);
        #2 rst = 1'b1;
        #1;
        check("async_reset", 32'({stream.out_valid, busy, done, beat_cnt, stream.out_data, inc_a}), 32'd0);
        cycle();
        rst = 1'b0;
        stream.out_ready = 1'b0;
        cycle();
        check("post_reset_idle", 32'({stream.out_valid, busy, done}), 32'd0);
        cycle();
        check("post_reset_no_done", 32'({done, beat_cnt}), 32'd0);

        // Random sequences against the arithmetic model.
        for (int k = 0; k < 24; k++) begin
            s  = 4'($urandom);
            e  = 4'($urandom);
            ab = (($urandom % 3) == 0) ? int'($urandom % 8) : -1;
            n  = ((int'(e) - int'(s)) & 15) + 1;
            run_seq(s, e, 2, ab, beats, aborted);
            check("rand_abort", 32'(aborted), 32'((ab >= 0) && (ab < n)));
            if (!aborted) check("rand_beats", 32'(beats), 32'(n));
            else check("rand_abort_beats", 32'((beats == ab) || (beats == ab + 1)), 32'd1);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
